// File: rtl/device_event_gen.sv
// Device event generator: walks the monitor's device count toward each accepted
// target by issuing one change strobe per device transition, up or down.
module device_event_gen #(
    parameter int GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [7:0] tgt_data,
    input  logic       abort,
    output logic       change,
    output logic       on_off,
    output logic       busy,
    output logic       done,
    output logic [7:0] model_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state, state_nx;
    logic [7:0] remaining, rem_nx;
    logic [7:0] count_nx;
    logic       dir, dir_nx;
    logic [3:0] gap_cnt, gap_nx;
    logic [7:0] delta;
    logic [8:0] plan;

    // Shortest way round the 256-count ring; a half-turn tie goes up.
    function automatic logic [8:0] plan_steps(input logic [7:0] d);
        if (d <= 8'd128)
            return {1'b1, d};
        else
            return {1'b0, 8'd0 - d};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            model_count <= 8'd0;
            remaining   <= 8'd0;
            dir         <= 1'b1;
            gap_cnt     <= 4'd0;
        end else begin
            state       <= state_nx;
            model_count <= count_nx;
            remaining   <= rem_nx;
            dir         <= dir_nx;
            gap_cnt     <= gap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = model_count;
        rem_nx   = remaining;
        dir_nx   = dir;
        gap_nx   = gap_cnt;
        delta    = tgt_data - model_count;
        plan     = plan_steps(delta);
        case (state)
            ST_IDLE: begin
                if (tgt_valid) begin
                    if (delta == 8'd0) begin
                        state_nx = ST_DONE;
                    end else begin
                        {dir_nx, rem_nx} = plan;
                        state_nx         = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                // The strobe in this cycle counts even if abort arrives with it.
                count_nx = dir ? model_count + 8'd1 : model_count - 8'd1;
                rem_nx   = remaining - 8'd1;
                if (abort)
                    state_nx = ST_IDLE;
                else if (remaining == 8'd1)
                    state_nx = ST_DONE;
                else if (GAP == 0)
                    state_nx = ST_EMIT;
                else begin
                    state_nx = ST_GAP;
                    gap_nx   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (gap_cnt == 4'd0)
                    state_nx = ST_EMIT;
                else
                    gap_nx = gap_cnt - 4'd1;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign change    = (state == ST_EMIT);
    assign on_off    = change & dir;
    assign busy      = (state == ST_EMIT) || (state == ST_GAP);
    assign done      = (state == ST_DONE);
    assign tgt_ready = (state == ST_IDLE);

endmodule
